// File: rtl/traffic_analyzer_gmii_capture_if.sv
// GMII capture port bundle: receive stream, capture controls, statistics and display-bank readout.
// The bench drives through master; the capture block attaches through slave.
interface traffic_analyzer_gmii_capture_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        gmii_d;
  logic              gmii_en;
  logic              gmii_er;
  logic              enable;
  logic [63:0]       ts_sec;
  logic [31:0]       ts_nsec;
  logic              frame_buf_hold;
  logic [ADDR_W-1:0] frame_buf_address;

  logic [63:0]       pkts;
  logic [63:0]       octets;
  logic [63:0]       octets_idle;
  logic [63:0]       pkts_err;
  logic [63:0]       timestamp_sec;
  logic [31:0]       timestamp_nsec;
  logic [31:0]       frame_size;
  logic [31:0]       frame_buf_data;

  modport master (
    output gmii_d, gmii_en, gmii_er, enable, ts_sec, ts_nsec,
           frame_buf_hold, frame_buf_address,
    input  pkts, octets, octets_idle, pkts_err, timestamp_sec,
           timestamp_nsec, frame_size, frame_buf_data
  );

  modport slave (
    input  gmii_d, gmii_en, gmii_er, enable, ts_sec, ts_nsec,
           frame_buf_hold, frame_buf_address,
    output pkts, octets, octets_idle, pkts_err, timestamp_sec,
           timestamp_nsec, frame_size, frame_buf_data
  );
endinterface

// File: rtl/traffic_analyzer_gmii_capture.sv
// GMII frame analyzer: traffic counters plus a double-buffered capture of the most recent frame,
// readable word by word from the display bank while the other bank fills.
module traffic_analyzer_gmii_capture #(
  parameter int BUF_WORDS = 256,
  parameter int ADDR_W    = 8
) (
  input logic                              clk,
  input logic                              reset,
  traffic_analyzer_gmii_capture_if.slave   gmii_if
);

  typedef enum logic [1:0] {IDLE, CAPTURE, SKIP} state_t;

  localparam int unsigned BUF_BYTES = 4 * BUF_WORDS;

  state_t      state_q, state_d;
  logic [63:0] pkts_q, pkts_d, octets_q, octets_d, idle_q, idle_d, err_cnt_q, err_cnt_d;
  logic [63:0] ts_sec_q, ts_sec_d, pend_sec_q, pend_sec_d;
  logic [31:0] ts_nsec_q, ts_nsec_d, pend_nsec_q, pend_nsec_d;
  logic [31:0] frame_size_q, frame_size_d, byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d, word_next, byte_idx;
  logic        frame_err_q, frame_err_d, bank_sel_q, bank_sel_d;
  logic        counted_byte;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data_q;
  logic [31:0]       bank_mem [2*BUF_WORDS];

  always_comb begin
    state_d      = state_q;
    pkts_d       = pkts_q;
    octets_d     = octets_q;
    idle_d       = idle_q;
    err_cnt_d    = err_cnt_q;
    ts_sec_d     = ts_sec_q;
    ts_nsec_d    = ts_nsec_q;
    pend_sec_d   = pend_sec_q;
    pend_nsec_d  = pend_nsec_q;
    frame_size_d = frame_size_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    frame_err_d  = frame_err_q;
    bank_sel_d   = bank_sel_q;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;

    counted_byte = gmii_if.gmii_en &&
                   (state_q == CAPTURE || (state_q == IDLE && gmii_if.enable));
    byte_idx     = (state_q == CAPTURE) ? byte_cnt_q : 32'd0;

    // Big-endian packing; lanes after the current byte are zero-filled.
    case (byte_idx[1:0])
      2'd0:    word_next = {gmii_if.gmii_d, 24'h0};
      2'd1:    word_next = {word_q[31:24], gmii_if.gmii_d, 16'h0};
      2'd2:    word_next = {word_q[31:16], gmii_if.gmii_d, 8'h0};
      default: word_next = {word_q[31:8], gmii_if.gmii_d};
    endcase

    if (!gmii_if.gmii_en && gmii_if.enable) idle_d = idle_q + 64'd1;

    case (state_q)
      IDLE: begin
        if (gmii_if.gmii_en) begin
          if (gmii_if.enable) begin
            state_d     = CAPTURE;
            pend_sec_d  = gmii_if.ts_sec;
            pend_nsec_d = gmii_if.ts_nsec;
            frame_err_d = gmii_if.gmii_er;
          end else begin
            state_d = SKIP;
          end
        end
      end
      CAPTURE: begin
        if (!gmii_if.gmii_en) begin
          state_d = IDLE;
          pkts_d  = pkts_q + 64'd1;
          if (frame_err_q) err_cnt_d = err_cnt_q + 64'd1;
          if (byte_cnt_q[1:0] != 2'd0 && byte_cnt_q < BUF_BYTES) begin
            wr_en   = 1'b1;
            wr_addr = byte_cnt_q[ADDR_W+1:2];
            wr_data = word_q;
          end
          if (!gmii_if.frame_buf_hold) begin
            bank_sel_d   = ~bank_sel_q;
            frame_size_d = byte_cnt_q;
            ts_sec_d     = pend_sec_q;
            ts_nsec_d    = pend_nsec_q;
          end
        end else if (gmii_if.gmii_er) begin
          frame_err_d = 1'b1;
        end
      end
      SKIP: begin
        if (!gmii_if.gmii_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (counted_byte) begin
      octets_d   = octets_q + 64'd1;
      word_d     = word_next;
      byte_cnt_d = (byte_idx == 32'hFFFF_FFFF) ? byte_idx : byte_idx + 32'd1;
      if (byte_idx[1:0] == 2'd3 && byte_idx < BUF_BYTES) begin
        wr_en   = 1'b1;
        wr_addr = byte_idx[ADDR_W+1:2];
        wr_data = word_next;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pkts_q       <= '0;
      octets_q     <= '0;
      idle_q       <= '0;
      err_cnt_q    <= '0;
      ts_sec_q     <= '0;
      ts_nsec_q    <= '0;
      pend_sec_q   <= '0;
      pend_nsec_q  <= '0;
      frame_size_q <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      frame_err_q  <= 1'b0;
      bank_sel_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pkts_q       <= pkts_d;
      octets_q     <= octets_d;
      idle_q       <= idle_d;
      err_cnt_q    <= err_cnt_d;
      ts_sec_q     <= ts_sec_d;
      ts_nsec_q    <= ts_nsec_d;
      pend_sec_q   <= pend_sec_d;
      pend_nsec_q  <= pend_nsec_d;
      frame_size_q <= frame_size_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      frame_err_q  <= frame_err_d;
      bank_sel_q   <= bank_sel_d;
    end
  end

  // NOTE: bank RAM has no reset so it maps onto block memory; stale words are expected after reset.
  always_ff @(posedge clk) begin
    if (wr_en) bank_mem[{~bank_sel_q, wr_addr}] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= bank_mem[{bank_sel_q, gmii_if.frame_buf_address}];
  end

  assign gmii_if.pkts           = pkts_q;
  assign gmii_if.octets         = octets_q;
  assign gmii_if.octets_idle    = idle_q;
  assign gmii_if.pkts_err       = err_cnt_q;
  assign gmii_if.timestamp_sec  = ts_sec_q;
  assign gmii_if.timestamp_nsec = ts_nsec_q;
  assign gmii_if.frame_size     = frame_size_q;
  assign gmii_if.frame_buf_data = rd_data_q;

endmodule

// File: tb/tb_traffic_analyzer_gmii_capture.sv
// Directed bench for traffic_analyzer_gmii_capture: counters, bank swap/hold, packing, limits, reset.
module tb_traffic_analyzer_gmii_capture;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  traffic_analyzer_gmii_capture_if #(.ADDR_W(8)) bus ();

  traffic_analyzer_gmii_capture #(.BUF_WORDS(256), .ADDR_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .gmii_if (bus.slave)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0]  fb [0:2047];
  logic [63:0] idle_model;
  logic [63:0] exp_pkts, exp_oct;

  // Reference idle-cycle count: every clocked cycle with gmii_en=0 and enable=1.
  always @(posedge clk or posedge reset) begin
    if (reset) idle_model = '0;
    else if (!bus.gmii_en && bus.enable) idle_model = idle_model + 64'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input int addr, input logic [31:0] exp, input string tag);
    bus.frame_buf_address = 8'(addr);
    tick(1);
    check(tag, {32'h0, bus.frame_buf_data}, {32'h0, exp});
  endtask

  // Expected word w of a frame of len bytes held in fb[].
  function automatic logic [31:0] exp_word(input int w, input int len);
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++)
      if (4*w + k < len) r[31-8*k -: 8] = fb[4*w + k];
    return r;
  endfunction

  // One byte per cycle from fb[]; ts values are only meaningful on the first byte.
  task automatic send_frame(input int len, input logic en_start, input int en_mid_idx,
                            input int er_idx, input logic [63:0] s, input logic [31:0] ns);
    for (int i = 0; i < len; i++) begin
      bus.gmii_en = 1'b1;
      bus.gmii_d  = fb[i];
      bus.gmii_er = (i == er_idx);
      if (i == 0) begin
        bus.enable  = en_start;
        bus.ts_sec  = s;
        bus.ts_nsec = ns;
      end else begin
        bus.ts_sec  = s + 64'(1000 + i);
        bus.ts_nsec = ns + 32'(1000 + i);
      end
      if (i == en_mid_idx) bus.enable = 1'b1;
      tick(1);
    end
    bus.gmii_en = 1'b0;
    bus.gmii_er = 1'b0;
    bus.gmii_d  = 8'h00;
  endtask

  initial begin
    reset = 1'b1;
    bus.gmii_d = 8'h00; bus.gmii_en = 1'b0; bus.gmii_er = 1'b0; bus.enable = 1'b0;
    bus.ts_sec = '0; bus.ts_nsec = '0; bus.frame_buf_hold = 1'b0; bus.frame_buf_address = '0;
    exp_pkts = 0; exp_oct = 0;
    tick(3);
    check("rst_pkts", bus.pkts, 64'd0);
    check("rst_octets", bus.octets, 64'd0);
    check("rst_idle", bus.octets_idle, 64'd0);
    check("rst_err", bus.pkts_err, 64'd0);
    check("rst_size", {32'h0, bus.frame_size}, 64'd0);
    check("rst_tsec", bus.timestamp_sec, 64'd0);
    check("rst_tnsec", {32'h0, bus.timestamp_nsec}, 64'd0);
    check("rst_data", {32'h0, bus.frame_buf_data}, 64'd0);
    reset = 1'b0;
    tick(2);

    // 64-byte frame 00..3F then 12 idle cycles (first of which ends the frame).
    for (int i = 0; i < 64; i++) fb[i] = 8'(i);
    send_frame(64, 1'b1, -1, -1, 64'd100, 32'd500);
    tick(12);
    exp_pkts = 1; exp_oct = 64;
    check("f64_pkts", bus.pkts, 64'd1);
    check("f64_octets", bus.octets, 64'd64);
    check("f64_idle", bus.octets_idle, 64'd12);
    check("f64_size", {32'h0, bus.frame_size}, 64'd64);
    check("f64_tsec", bus.timestamp_sec, 64'd100);
    check("f64_tnsec", {32'h0, bus.timestamp_nsec}, 64'd500);
    rd(0, 32'h0001_0203, "f64_w0");
    rd(15, 32'h3C3D_3E3F, "f64_w15");

    // 6-byte frame with the one-cycle read latency checked.
    for (int i = 0; i < 6; i++) fb[i] = 8'hAA + 8'(i);
    send_frame(6, 1'b1, -1, -1, 64'd200, 32'd600);
    tick(1);
    exp_pkts++; exp_oct += 6;
    check("f6_size", {32'h0, bus.frame_size}, 64'd6);
    check("f6_pkts", bus.pkts, exp_pkts);
    rd(0, 32'hAAAB_ACAD, "f6_w0");
    bus.frame_buf_address = 8'd1;
    #1;
    check("f6_latency", {32'h0, bus.frame_buf_data}, 64'hAAAB_ACAD);
    tick(1);
    check("f6_w1", {32'h0, bus.frame_buf_data}, 64'hAEAF_0000);

    // Hold: a 10-byte frame is counted but the display stays on the 6-byte frame.
    bus.frame_buf_hold = 1'b1;
    for (int i = 0; i < 10; i++) fb[i] = 8'h10 + 8'(i);
    send_frame(10, 1'b1, -1, -1, 64'd300, 32'd700);
    tick(1);
    exp_pkts++; exp_oct += 10;
    check("hold_size", {32'h0, bus.frame_size}, 64'd6);
    check("hold_tsec", bus.timestamp_sec, 64'd200);
    check("hold_pkts", bus.pkts, exp_pkts);
    check("hold_octets", bus.octets, exp_oct);
    rd(1, 32'hAEAF_0000, "hold_w1");
    bus.frame_buf_hold = 1'b0;

    // Errored 8-byte frame.
    for (int i = 0; i < 8; i++) fb[i] = 8'h40 + 8'(i);
    send_frame(8, 1'b1, -1, 3, 64'd400, 32'd800);
    tick(1);
    exp_pkts++; exp_oct += 8;
    check("err_cnt", bus.pkts_err, 64'd1);
    check("err_pkts", bus.pkts, exp_pkts);

    // Frame started with enable=0; enable rises mid-frame: no counting.
    bus.enable = 1'b0;
    tick(1);
    send_frame(5, 1'b0, 2, -1, 64'd500, 32'd900);
    tick(2);
    check("skip_pkts", bus.pkts, exp_pkts);
    check("skip_octets", bus.octets, exp_oct);
    check("skip_size", {32'h0, bus.frame_size}, 64'd8);
    check("skip_err", bus.pkts_err, 64'd1);

    // Single-byte frame.
    fb[0] = 8'h5A;
    send_frame(1, 1'b1, -1, -1, 64'd600, 32'd1000);
    tick(1);
    exp_pkts++; exp_oct += 1;
    check("one_size", {32'h0, bus.frame_size}, 64'd1);
    check("one_pkts", bus.pkts, exp_pkts);
    rd(0, 32'h5A00_0000, "one_w0");

    // Back-to-back frames with a single idle cycle between them.
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03;
    send_frame(3, 1'b1, -1, -1, 64'd700, 32'd1100);
    tick(1);
    for (int i = 0; i < 5; i++) fb[i] = 8'hB0 + 8'(i);
    send_frame(5, 1'b1, -1, -1, 64'd710, 32'd1110);
    tick(1);
    exp_pkts += 2; exp_oct += 8;
    check("b2b_pkts", bus.pkts, exp_pkts);
    check("b2b_size", {32'h0, bus.frame_size}, 64'd5);
    check("b2b_tnsec", {32'h0, bus.timestamp_nsec}, 64'd1110);
    rd(0, 32'hB0B1_B2B3, "b2b_w0");
    rd(1, 32'hB400_0000, "b2b_w1");

    // 2000-byte frame overruns the 1024-byte bank: tail counted, not stored.
    for (int i = 0; i < 2000; i++) fb[i] = 8'(i*7 + 3);
    send_frame(2000, 1'b1, -1, -1, 64'h0000_0001_2345_6789, 32'h3B9A_C9FF);
    tick(1);
    exp_pkts++; exp_oct += 2000;
    check("big_size", {32'h0, bus.frame_size}, 64'd2000);
    check("big_octets", bus.octets, exp_oct);
    check("big_pkts", bus.pkts, exp_pkts);
    check("big_tsec", bus.timestamp_sec, 64'h0000_0001_2345_6789);
    check("big_tnsec", {32'h0, bus.timestamp_nsec}, 64'h3B9A_C9FF);
    rd(255, exp_word(255, 2000), "big_w255");
    rd(0, exp_word(0, 2000), "big_w0");
    rd(100, exp_word(100, 2000), "big_w100");
    check("idle_model", bus.octets_idle, idle_model);

    // Asynchronous reset while byte 20 of a frame is on the wire.
    for (int i = 0; i < 20; i++) begin
      bus.gmii_en = 1'b1; bus.gmii_d = 8'(i);
      tick(1);
    end
    bus.gmii_d = 8'd20;
    #2;
    reset = 1'b1;
    #1;
    check("arst_pkts", bus.pkts, 64'd0);
    check("arst_octets", bus.octets, 64'd0);
    check("arst_idle", bus.octets_idle, 64'd0);
    check("arst_size", {32'h0, bus.frame_size}, 64'd0);
    check("arst_tsec", bus.timestamp_sec, 64'd0);
    check("arst_data", {32'h0, bus.frame_buf_data}, 64'd0);
    bus.gmii_en = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(3);
    check("arst_pkts_after", bus.pkts, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/traffic_analyzer_gmii_capture.md
TRAFFIC_ANALYZER_GMII_CAPTURE -- requirements
Module: traffic_analyzer_gmii_capture

Interface
REQ-001 Parameter BUF_WORDS, default 256, depth in 32-bit words of each frame capture bank (power of two).
REQ-002 Parameter ADDR_W, default 8, equal to log2(BUF_WORDS).
REQ-003 clk  in  1  single clock; all ports synchronous to it.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 gmii_d  in  8  GMII receive data byte.
REQ-006 gmii_en  in  1  GMII receive data valid; a frame is each contiguous run of gmii_en=1.
REQ-007 gmii_er  in  1  GMII receive error; marks the current frame errored.
REQ-008 enable  in  1  capture/count enable (control register bit 0).
REQ-009 ts_sec  in  64  free-running seconds timestamp.
REQ-010 ts_nsec  in  32  free-running nanoseconds timestamp.
REQ-011 frame_buf_hold  in  1  1 = freeze the display bank (no bank swap).
REQ-012 frame_buf_address  in  ADDR_W  word address into the display bank.
REQ-013 pkts  out  64  frames received; octets  out  64  bytes with gmii_en=1; octets_idle  out  64  cycles with gmii_en=0.
REQ-014 pkts_err  out  64  frames with gmii_er seen.
REQ-015 timestamp_sec  out  64, timestamp_nsec  out  32  start time of the displayed frame.
REQ-016 frame_size  out  32  byte length of the displayed frame.
REQ-017 frame_buf_data  out  32  display-bank word at frame_buf_address.

Function
REQ-018 FSM states: IDLE, CAPTURE, SKIP; a frame start is gmii_en=1 while in IDLE.
REQ-019 IDLE: on frame start with enable=1 -> CAPTURE; with enable=0 -> SKIP.
REQ-020 CAPTURE/SKIP: on gmii_en=0 -> IDLE; enable changes mid-frame are ignored until the next frame start.
REQ-021 octets increments by 1 each cycle gmii_en=1 in a counted frame (frame started with enable=1); octets_idle increments each cycle gmii_en=0 while enable=1; all counters wrap modulo 2^64.
REQ-022 On frame start in IDLE with enable=1, ts_sec/ts_nsec of that cycle are latched into pending timestamp registers.
REQ-023 Capture bytes pack big-endian into 32-bit words: byte n of the frame goes to word n/4, bits [31-8*(n mod 4) -: 8]; unused trailing bytes of the last word are 0.
REQ-024 Each word is written to the capture bank on its 4th byte, or on frame end if partial; bytes beyond 4*BUF_WORDS are counted but not stored.
REQ-025 Frame end (first cycle gmii_en=0 in CAPTURE): pkts += 1; pkts_err += 1 if gmii_er was 1 on any cycle of the frame; pending size/timestamp committed.
REQ-026 On frame end with frame_buf_hold=0: capture and display banks swap, and frame_size, timestamp_sec, timestamp_nsec update in the same cycle (1 cycle after the last byte).
REQ-027 On frame end with frame_buf_hold=1: no swap, frame_size/timestamps unchanged; counters still update.
REQ-028 frame_size is a 32-bit byte count, saturating at 2^32-1.
REQ-029 frame_buf_data is registered: valid 1 clk cycle after frame_buf_address changes; reading words at or beyond the displayed frame's length returns stale bank contents, not zero.
REQ-030 SKIP frames affect no counter, bank, or register.
REQ-031 A 1-cycle frame (single byte) is valid: pkts +1, frame_size = 1, word 0 = {byte, 24'h0}.
REQ-032 Back-to-back frames separated by one idle cycle are each counted and captured correctly.

Reset
REQ-033 Reset (async assert, sync release) sets state IDLE, pkts, octets, octets_idle, pkts_err, frame_size, timestamp_sec, timestamp_nsec, frame_buf_data to 0 and bank select to 0.
REQ-034 Bank RAM contents are not reset.
REQ-035 Reset mid-frame discards the frame; after release with gmii_en still 1, the remainder is treated as a new frame start.

Verification
REQ-036 enable=1, 64-byte frame 00..3F, 12 idle cycles -> pkts=1, octets=64, octets_idle=12, frame_size=64, word0=0x00010203, word15=0x3C3D3E3F.
REQ-037 Frame of 6 bytes AA..AF -> frame_size=6, word1=0xAEAF0000, data valid 1 cycle after address applied.
REQ-038 frame_buf_hold=1, then a second frame of 10 bytes -> frame_size and word contents still from the first frame; pkts=2.
REQ-039 gmii_er=1 for one cycle mid-frame -> pkts_err=1, pkts=1; frame started with enable=0 then enable=1 mid-frame -> no counter changes.
REQ-040 2000-byte frame -> frame_size=2000, octets +2000, word255 = bytes 1020..1023; pending ts latched at start cycle matches timestamp_sec/nsec.
REQ-041 Assert reset during frame byte 20 -> all outputs 0 immediately (asynchronously); pkts stays 0.
